// File: rtl/pipe_fetch_decode.sv
// Fetch and decode front end: registered pc, one decode register, one-cycle branch/JR
// resolution with a 3-cycle squash window. Optional JR decode is enabled with `define JR_EN.
`timescale 1ns/1ps
module pipe_fetch_decode #(
  parameter logic [2:0] ALU_ADD = 3'b010,
  parameter logic [2:0] ALU_SUB = 3'b011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic [8:0]  pc,
  output logic        halted,
  input  logic        execCFlag,
  input  logic        execNFlag,
  input  logic        execVFlag,
  input  logic        execZFlag,
  input  logic [8:0]  execRfRdData0Short,
  output logic [15:0] decodeImmediate,
  output logic [4:0]  decodeRfRdAdrx0,
  output logic [4:0]  decodeRfRdAdrx1,
  output logic [4:0]  decodeRfWrAdrx,
  output logic [2:0]  decodeAluCtl,
  output logic        decodeRfWriteEn,
  output logic        decodeAluBusBSel,
  output logic        decodeDmemResultSel,
  output logic        decodeRegDest,
  output logic        dmemWriteEn,
  output logic        doBranch3Held
);

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_RTYPE  = 3'b001;
  localparam logic [2:0] OP_ITYPE  = 3'b010;
  localparam logic [2:0] OP_LOAD   = 3'b011;
  localparam logic [2:0] OP_STORE  = 3'b100;
  localparam logic [2:0] OP_BRANCH = 3'b101;
  localparam logic [2:0] OP_JR     = 3'b110;
  localparam logic [2:0] OP_HALT   = 3'b111;

  logic [31:0] d_instr;
  logic [8:0]  d_pc;
  logic [2:0]  op;
  logic [2:0]  fn;

  logic        pend_valid;
  logic        pend_jr;
  logic [2:0]  pend_fn;
  logic [8:0]  pend_target;
  logic [1:0]  hold_cnt;

  logic        squash;
  logic        decode_branch;
  logic        decode_jr;
  logic        decode_halt;
  logic        cond_met;
  logic        take;
  logic        halt_now;
  logic [8:0]  branch_target;

  assign op            = d_instr[31:29];
  assign fn            = d_instr[28:26];
  assign doBranch3Held = (hold_cnt != 2'd0);
  assign squash        = doBranch3Held | halted;

  assign decode_branch = (op == OP_BRANCH) & ~squash;
  assign decode_halt   = (op == OP_HALT) & ~squash;
`ifdef JR_EN
  assign decode_jr     = (op == OP_JR) & ~squash;
`else
  assign decode_jr     = 1'b0;
`endif

  // 9-bit offset is already sign-correct modulo 512, so no explicit extension is needed.
  assign branch_target = d_pc + 9'd1 + d_instr[8:0];

  always_comb begin
    cond_met = 1'b0;
    case (pend_fn)
      3'b000:  cond_met = 1'b1;
      3'b001:  cond_met = execZFlag;
      3'b010:  cond_met = ~execZFlag;
      3'b011:  cond_met = execNFlag;
      3'b100:  cond_met = ~execNFlag;
      3'b101:  cond_met = execCFlag;
      3'b110:  cond_met = execVFlag;
      default: cond_met = 1'b0;
    endcase
  end

  assign take     = pend_valid & (pend_jr | cond_met);
  // A resolving taken branch wins over a HALT sitting in decode.
  assign halt_now = decode_halt & ~take;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= 9'd0;
      d_pc        <= 9'd0;
      d_instr     <= 32'h0;
      pend_valid  <= 1'b0;
      pend_jr     <= 1'b0;
      pend_fn     <= 3'b000;
      pend_target <= 9'd0;
      hold_cnt    <= 2'd0;
      halted      <= 1'b0;
    end else begin
      pend_valid  <= decode_branch | decode_jr;
      pend_jr     <= decode_jr;
      pend_fn     <= fn;
      pend_target <= decode_jr ? execRfRdData0Short : branch_target;

      if (take) begin
        hold_cnt <= 2'd3;
      end else if (hold_cnt != 2'd0) begin
        hold_cnt <= hold_cnt - 2'd1;
      end

      if (take) begin
        pc <= pend_target;
      end else if (!(halted || halt_now)) begin
        pc <= pc + 9'd1;
      end

      if (take || !(halted || halt_now)) begin
        d_instr <= instr;
        d_pc    <= pc;
      end

      halted <= halted | halt_now;
    end
  end

  assign decodeImmediate = d_instr[15:0];
  assign decodeRfRdAdrx0 = d_instr[25:21];
  assign decodeRfRdAdrx1 = d_instr[20:16];
  assign decodeRfWrAdrx  = d_instr[15:11];

  always_comb begin
    decodeAluCtl        = 3'b000;
    decodeRfWriteEn     = 1'b0;
    decodeAluBusBSel    = 1'b0;
    decodeDmemResultSel = 1'b0;
    decodeRegDest       = 1'b0;
    dmemWriteEn         = 1'b0;
    if (!squash) begin
      case (op)
        OP_RTYPE: begin
          decodeAluCtl    = fn;
          decodeRfWriteEn = 1'b1;
          decodeRegDest   = 1'b1;
        end
        OP_ITYPE: begin
          decodeAluCtl     = fn;
          decodeRfWriteEn  = 1'b1;
          decodeAluBusBSel = 1'b1;
        end
        OP_LOAD: begin
          decodeAluCtl        = ALU_ADD;
          decodeRfWriteEn     = 1'b1;
          decodeAluBusBSel    = 1'b1;
          decodeDmemResultSel = 1'b1;
        end
        OP_STORE: begin
          decodeAluCtl     = ALU_ADD;
          decodeAluBusBSel = 1'b1;
          dmemWriteEn      = 1'b1;
        end
        OP_BRANCH: decodeAluCtl = ALU_SUB;
        // NOP, JR and HALT drive no datapath controls.
        default: decodeAluCtl = 3'b000;
      endcase
    end
  end

endmodule

// File: doc/pipe_fetch_decode.md
PIPE_FETCH_DECODE -- requirements
Module: pipe_fetch_decode

Interface
REQ-001 Parameter ALU_ADD, default 3'b010: ALU control code forced for LOAD and STORE.
REQ-002 Parameter ALU_SUB, default 3'b011: ALU control code forced for BRANCH (rs - rt compare).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instr  input  32  instruction word from imem at address pc, valid in the same cycle.
REQ-006 pc  output  9  fetch address, registered.
REQ-007 halted  output  1  high once HALT is decoded; stays high until reset.
REQ-008 execCFlag  input  1  carry flag, registered at the end of execute.
REQ-009 execNFlag  input  1  negative flag, registered at the end of execute.
REQ-010 execVFlag  input  1  overflow flag, registered at the end of execute.
REQ-011 execZFlag  input  1  zero flag, registered at the end of execute.
REQ-012 execRfRdData0Short  input  9  rs read data (low 9 bits), registered at the end of execute; the JR target.
REQ-013 decodeImmediate  output  16  instr[15:0] of the decode-stage word.
REQ-014 decodeRfRdAdrx0  output  5  rs = instr[25:21].
REQ-015 decodeRfRdAdrx1  output  5  rt = instr[20:16].
REQ-016 decodeRfWrAdrx  output  5  rd = instr[15:11].
REQ-017 decodeAluCtl  output  3  ALU operation.
REQ-018 decodeRfWriteEn  output  1  instruction writes the register file.
REQ-019 decodeAluBusBSel  output  1  1 selects the immediate for ALU bus B.
REQ-020 decodeDmemResultSel  output  1  1 selects dmem data for writeback.
REQ-021 decodeRegDest  output  1  1 writes rd, 0 writes rt.
REQ-022 dmemWriteEn  output  1  store strobe for the decode/execute cycle.
REQ-023 doBranch3Held  output  1  suppresses execute-stage writeback of wrong-path instructions.

Function
REQ-024 The block SHALL keep one decode register (dInstr) loaded from instr each cycle; all decode* outputs SHALL be combinational from dInstr. op = dInstr[31:29], fn = dInstr[28:26].
REQ-025 Decode SHALL follow the opcode table; every control not listed is 0.
- op 000 NOP: all controls 0.
- op 001 RTYPE: aluCtl=fn, RfWriteEn=1, RegDest=1.
- op 010 ITYPE: aluCtl=fn, RfWriteEn=1, AluBusBSel=1.
- op 011 LOAD: aluCtl=ALU_ADD, RfWriteEn=1, AluBusBSel=1, DmemResultSel=1.
- op 100 STORE: aluCtl=ALU_ADD, AluBusBSel=1, dmemWriteEn=1.
- op 101 BRANCH: aluCtl=ALU_SUB.
- op 110 JR.
- op 111 HALT.
REQ-026 pc SHALL increment by 1 each cycle, wrapping from 511 to 0, unless redirected or halted.
REQ-027 A BRANCH or JR in decode in cycle t SHALL be captured into a pending register with its target: for BRANCH, pc_of_instr + 1 + sign-extended dInstr[8:0] (mod 512); for JR, taken from execRfRdData0Short.
REQ-028 Branches SHALL resolve in cycle t+1 on the exec flags.
- fn conditions: 000 always, 001 Z, 010 !Z, 011 N, 100 !N, 101 C, 110 V, 111 never.
- JR is always taken.
REQ-029 Taken resolution SHALL set pc <= target and load a hold counter with 3; doBranch3Held = (counter != 0), and the counter SHALL decrement per cycle.
REQ-030 While doBranch3Held is high, decode* controls and dmemWriteEn SHALL be forced to NOP values, and BRANCH, JR and HALT in decode SHALL be ignored.
REQ-031 A not-taken branch SHALL cause no hold and no pc change.
REQ-032 A non-squashed HALT SHALL freeze pc and dInstr, assert halted and force NOP controls; a pending taken branch resolving in the same cycle SHALL take priority over HALT.

Reset
REQ-033 On reset the block SHALL set pc=0, dInstr=NOP (32'h0), pending=0, hold counter=0, halted=0, so all decode* outputs, dmemWriteEn and doBranch3Held are 0 in the following cycle.
REQ-034 Reset asserted mid-hold or mid-branch SHALL discard the hold and the pending target.

Configuration
REQ-035 With JR_EN defined, op 110 SHALL decode as JR per REQ-027; without it, op 110 SHALL decode as NOP and never redirect.

Verification
REQ-036 Reset, then NOP stream -> pc = 0,1,2,...; all controls 0; doBranch3Held=0.
REQ-037 RTYPE fn=001 rs=1 rt=2 rd=3 -> aluCtl=001, RfWriteEn=1, RegDest=1, WrAdrx=3; LOAD rt=4 imm=16 -> aluCtl=ALU_ADD, BusBSel=1, DmemResultSel=1.
REQ-038 BRANCH fn=001 imm=5 fetched at pc=10, execZFlag=1 next cycle -> pc=16, doBranch3Held high exactly 3 cycles, wrong-path STORE gives dmemWriteEn=0.
REQ-039 Same branch with execZFlag=0 -> pc continues 11,12,13; doBranch3Held stays 0.
REQ-040 JR with execRfRdData0Short=9'h1F0 (JR_EN defined) -> pc=496; without JR_EN -> no redirect; HALT at pc=20 -> pc frozen, halted=1; reset asserted during hold -> counter cleared.
